arm_seq: RTL and testbench

ARM_SEQ -- requirements
Module: arm_seq

---
 rtl/arm_seq_if.sv | 29 ++
 rtl/arm_seq.sv | 113 +++++++++++
 tb/tb_arm_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_seq_if.sv
// Sequencer-to-core handshake bundle: instruction fetch, decode/execute start-done, and status.
// The master side is the sequencer; the slave side is the memory, decoder and execute unit.
interface arm_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        decode_en;
  logic [31:0] instr;
  logic        decode_done;
  logic        cond_pass;
  logic        exec_en;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        fault;

  modport master (
    output imem_req, imem_addr, decode_en, instr, exec_en, pc, retired, fault,
    input  imem_ready, imem_rdata, decode_done, cond_pass, exec_done, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, decode_en, instr, exec_en, pc, retired, fault,
    output imem_ready, imem_rdata, decode_done, cond_pass, exec_done, branch_taken, branch_target
  );
endinterface

// File: rtl/arm_seq.sv
// Fetch/decode/execute sequencer: 5-cycle minimum fetch-to-fetch, fetch waits unbounded on imem_ready,
// decode/execute completions wait at most TIMEOUT cycles before a sticky fault halts the sequencer.
module arm_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic       clk,
  input logic       rst_n,
  arm_seq_if.master bus
);
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   retired_q, retired_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          first_q, first_d;
  logic          run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      fault_q   <= 1'b0;
      wait_q    <= '0;
      first_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      first_q   <= first_d;
      run_q     <= 1'b1;
    end
  end

  // first_q marks the start-pulse cycle; a completion seen alongside the pulse is not accepted
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    first_d   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (run_q && bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          state_d = DECODE;
          first_d = 1'b1;
          wait_d  = '0;
        end
      end
      DECODE: begin
        if (!first_q && bus.decode_done) begin
          if (bus.cond_pass) begin
            state_d = EXEC;
            first_d = 1'b1;
            wait_d  = '0;
          end else begin
            pc_d      = pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
            state_d   = FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EXEC: begin
        if (!first_q && bus.exec_done) begin
          pc_d      = bus.branch_taken ? {bus.branch_target[31:2], 2'b00} : pc_q + 32'd4;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // run_q keeps imem_req low through reset and the cycle that follows release
  assign bus.imem_req  = (state_q == FETCH) && run_q;
  assign bus.imem_addr = (state_q == HALT) ? 32'd0 : pc_q;
  assign bus.decode_en = (state_q == DECODE) && first_q;
  assign bus.exec_en   = (state_q == EXEC) && first_q;
  assign bus.instr     = instr_q;
  assign bus.pc        = pc_q;
  assign bus.retired   = retired_q;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_arm_seq.sv
// Bench for arm_seq: directed instruction vectors; a monitor pops expected fetches from a scoreboard queue.
module tb_arm_seq;
  logic clk;
  logic rst_n;

  arm_seq_if bus();

  arm_seq #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ret;
    int          gap;
  } fexp_t;

  fexp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int last_fetch = 0;
  int dec_pulses = 0;
  int exec_pulses = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic void chkb(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  // Monitor: every accepted fetch must match the next scoreboard entry
  initial begin
    fexp_t e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.decode_en) dec_pulses++;
      if (bus.exec_en) exec_pulses++;
      if (rst_n && bus.imem_req && bus.imem_ready) begin
        if (exp_q.size() == 0) begin
          chkb("fetch_unexpected", bus.imem_req, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_addr", bus.imem_addr, e.addr);
          chk("fetch_retired", bus.retired, e.ret);
          if (e.gap >= 0) chk("fetch_gap", cyc - last_fetch, e.gap);
        end
        last_fetch = cyc;
      end
    end
  end

  // Called at a negedge; returns at the negedge where the sequencer is back in FETCH
  // (or, with withhold, at the negedge just after the exec_en pulse).
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] ret, input int gap,
                           input logic [31:0] word, input logic cp, input logic bt,
                           input logic [31:0] tgt, input logic early, input logic withhold);
    int n;
    n = 0;
    while (!bus.imem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      chkb("fetch_wait", bus.imem_req, 1'b1);
      return;
    end
    exp_q.push_back('{addr, ret, gap});
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    chk("instr_latch", bus.instr, word);
    chkb("decode_en_pulse", bus.decode_en, 1'b1);
    bus.decode_done = early;
    bus.cond_pass   = cp;
    @(negedge clk);
    chkb("decode_en_width", bus.decode_en, 1'b0);
    bus.decode_done = 1'b1;
    @(negedge clk);
    bus.decode_done = 1'b0;
    if (!cp) begin
      chkb("skip_no_exec", bus.exec_en, 1'b0);
      chkb("skip_refetch", bus.imem_req, 1'b1);
      return;
    end
    chkb("exec_en_pulse", bus.exec_en, 1'b1);
    bus.exec_done     = early;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    @(negedge clk);
    chkb("exec_en_width", bus.exec_en, 1'b0);
    if (withhold) begin
      bus.exec_done = 1'b0;
      return;
    end
    bus.exec_done = 1'b1;
    @(negedge clk);
    bus.exec_done    = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  initial begin
    logic        stable;
    logic [31:0] addr0;
    int          d0;
    int          e0;
    rst_n             = 1'b0;
    bus.imem_ready    = 1'b0;
    bus.imem_rdata    = 32'd0;
    bus.decode_done   = 1'b0;
    bus.cond_pass     = 1'b0;
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    repeat (3) @(negedge clk);
    chkb("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_retired", bus.retired, 32'h0);
    chkb("rst_fault", bus.fault, 1'b0);
    chkb("rst_decode_en", bus.decode_en, 1'b0);
    chkb("rst_exec_en", bus.exec_en, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("req_after_release", bus.imem_req, 1'b1);

    // Straight-line run, then a condition-failed instruction, then a taken branch with early dones
    run_instr(32'h0000_0000, 32'd0, -1, 32'hE000_0001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    run_instr(32'h0000_0004, 32'd1,  5, 32'hE000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    run_instr(32'h0000_0008, 32'd2,  5, 32'hE000_0003, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("retired_after3", bus.retired, 32'd3);
    chk("pc_after3", bus.pc, 32'h0000_000C);
    e0 = exec_pulses;
    run_instr(32'h0000_000C, 32'd3,  5, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("skip_pc", bus.pc, 32'h0000_0010);
    chk("skip_exec_count", exec_pulses, e0);
    run_instr(32'h0000_0010, 32'd4,  3, 32'hEA00_0005, 1'b1, 1'b1, 32'h0000_1003, 1'b1, 1'b0);
    run_instr(32'h0000_1000, 32'd5,  5, 32'hE000_0006, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Execute timeout
    run_instr(32'h0000_1004, 32'd6,  5, 32'hE000_0007, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    chkb("fault_not_early", bus.fault, 1'b0);
    repeat (10) @(negedge clk);
    chkb("fault_set", bus.fault, 1'b1);
    chk("halt_pc", bus.pc, 32'h0000_1004);
    chk("halt_retired", bus.retired, 32'd6);
    chk("halt_instr", bus.instr, 32'hE000_0007);
    chk("halt_imem_addr", bus.imem_addr, 32'h0);
    stable = 1'b1;
    bus.imem_ready  = 1'b1;
    bus.decode_done = 1'b1;
    bus.exec_done   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req || bus.decode_en || bus.exec_en || !bus.fault) stable = 1'b0;
    end
    chkb("halt_quiet", stable, 1'b1);
    bus.imem_ready  = 1'b0;
    bus.decode_done = 1'b0;
    bus.exec_done   = 1'b0;

    rst_n = 1'b0;
    #1;
    chkb("rst2_fault", bus.fault, 1'b0);
    chk("rst2_pc", bus.pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_fetch_addr", bus.imem_addr, 32'h0);

    // Branch to the top of memory, stall the fetch there, then wrap
    run_instr(32'h0000_0000, 32'd0, -1, 32'hEA00_0008, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    stable = 1'b1;
    addr0  = bus.imem_addr;
    repeat (40) begin
      @(negedge clk);
      if (!bus.imem_req || bus.imem_addr !== addr0 || bus.fault) stable = 1'b0;
    end
    chkb("stall_stable", stable, 1'b1);
    chk("stall_addr", addr0, 32'hFFFF_FFFC);
    run_instr(32'hFFFF_FFFC, 32'd1, -1, 32'hE000_0009, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap_pc", bus.pc, 32'h0);

    // Asynchronous reset while execute is outstanding
    run_instr(32'h0000_0000, 32'd2,  5, 32'hE000_000A, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chkb("arst_imem_req", bus.imem_req, 1'b0);
    chkb("arst_exec_en", bus.exec_en, 1'b0);
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_retired", bus.retired, 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.exec_done = 1'b1;
    bus.decode_done = 1'b1;
    d0 = dec_pulses;
    e0 = exec_pulses;
    repeat (4) @(negedge clk);
    chk("arst_no_decode_en", dec_pulses, d0);
    chk("arst_no_exec_en", exec_pulses, e0);
    chkb("arst_refetch", bus.imem_req, 1'b1);
    bus.exec_done = 1'b0;
    bus.decode_done = 1'b0;
    run_instr(32'h0000_0000, 32'd0, -1, 32'hE000_000B, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("final_retired", bus.retired, 32'd1);
    chk("final_pc", bus.pc, 32'h0000_0004);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
